// File: rtl/core_pkg.sv
// Shared definitions for the instruction generator: inst field positions,
// the idle instruction word and the sequencer state encoding.
package core_pkg;

    localparam int INST_W = 35;
    localparam int ADDR_W = 11;
    localparam int KIJ_W  = 4;
    localparam int CNT_W  = 11;

    localparam int SFU_EN_BIT    = 34;
    localparam int ACC_BIT       = 33;
    localparam int PSUM_CEN_BIT  = 32;
    localparam int PSUM_WEN_BIT  = 31;
    localparam int PSUM_ADDR_LSB = 20;
    localparam int XMEM_CEN_BIT  = 19;
    localparam int XMEM_WEN_BIT  = 18;
    localparam int XMEM_ADDR_LSB = 7;
    localparam int OFIFO_RD_BIT  = 6;
    localparam int IFIFO_WR_BIT  = 5;
    localparam int IFIFO_RD_BIT  = 4;
    localparam int L0_RD_BIT     = 3;
    localparam int L0_WR_BIT     = 2;
    localparam int EXECUTE_BIT   = 1;
    localparam int LOAD_BIT      = 0;

    // Both SRAM chip-enables deasserted (active-low), every strobe off.
    localparam logic [INST_W-1:0] IDLE_WORD = 35'h100080000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WMEM,
        S_WARR,
        S_WGAP,
        S_XMEM,
        S_EXEC,
        S_DRAIN,
        S_DONE
    } state_e;

    function automatic logic [ADDR_W-1:0] addr_trunc(input int v);
        return v[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/inst_gen_if.sv
// Handshake bundle between the instruction generator and the core/controller.
interface inst_gen_if;
    import core_pkg::*;

    logic              start;
    logic              ofifo_valid;
    logic [INST_W-1:0] inst;
    logic              busy;
    logic              done;
    logic [KIJ_W-1:0]  kij;

    modport master (
        output start,
        output ofifo_valid,
        input  inst,
        input  busy,
        input  done,
        input  kij
    );

    modport slave (
        input  start,
        input  ofifo_valid,
        output inst,
        output busy,
        output done,
        output kij
    );

endinterface

// File: rtl/inst_gen_step_cnt.sv
// Loadable up-counter with a terminal-count flag; also exposes its next value
// so the owner can decode registered outputs aligned with the count.
module step_cnt #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] nxt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign nxt_o = cnt_d;
    assign tc_o  = (cnt_q == last_i);

endmodule

// File: rtl/inst_gen.sv
// Weight-stationary pass sequencer: walks every kernel position, emitting the
// registered 35-bit core instruction for weight load, activation stream and psum drain.
module inst_gen
    import core_pkg::*;
#(
    parameter int ROW     = 8,
    parameter int COL     = 8,
    parameter int LEN_KIJ = 9,
    parameter int LEN_NIJ = 36,
    parameter int W_BASE  = 1024
) (
    input  logic       clk,
    input  logic       reset,
    inst_gen_if.slave  bus
);

    // Parameters must keep W_BASE+LEN_KIJ*COL and LEN_KIJ*LEN_NIJ within 11 bits.
    localparam logic [CNT_W-1:0] WMEM_LAST = CNT_W'(COL);
    localparam logic [CNT_W-1:0] WARR_LAST = CNT_W'(COL - 1);
    localparam logic [CNT_W-1:0] WGAP_LAST = CNT_W'(ROW + COL - 1);
    localparam logic [CNT_W-1:0] XMEM_LAST = CNT_W'(LEN_NIJ);
    localparam logic [CNT_W-1:0] EXEC_LAST = CNT_W'(LEN_NIJ - 1);
    localparam logic [CNT_W-1:0] COL_CNT   = CNT_W'(COL);
    localparam logic [CNT_W-1:0] NIJ_CNT   = CNT_W'(LEN_NIJ);
    localparam logic [KIJ_W-1:0] KIJ_LAST  = KIJ_W'(LEN_KIJ - 1);

    state_e            state_q;
    state_e            state_d;
    logic [KIJ_W-1:0]  kij_q;
    logic [KIJ_W-1:0]  kij_d;
    logic [CNT_W-1:0]  rd_q;
    logic [CNT_W-1:0]  rd_d;
    logic [CNT_W-1:0]  wr_q;
    logic [CNT_W-1:0]  wr_d;
    logic [CNT_W-1:0]  rd_base;
    logic [CNT_W-1:0]  wr_base;
    logic              rd_fire;
    logic              wr_fire;
    logic [INST_W-1:0] inst_q;
    logic [INST_W-1:0] inst_d;
    logic              busy_q;
    logic              busy_d;
    logic              done_q;
    logic              done_d;

    logic              ph_load;
    logic              ph_en;
    logic [CNT_W-1:0]  ph_last;
    logic [CNT_W-1:0]  ph_nxt;
    logic              ph_tc;

    step_cnt #(.W(CNT_W)) u_phase (
        .clk        (clk),
        .reset      (reset),
        .load_i     (ph_load),
        .load_val_i ({CNT_W{1'b0}}),
        .en_i       (ph_en),
        .last_i     (ph_last),
        .nxt_o      (ph_nxt),
        .tc_o       (ph_tc)
    );

    always_comb begin
        state_d = state_q;
        kij_d   = kij_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_WMEM;
            S_WMEM:  if (ph_tc) state_d = S_WARR;
            S_WARR:  if (ph_tc) state_d = S_WGAP;
            S_WGAP:  if (ph_tc) state_d = S_XMEM;
            S_XMEM:  if (ph_tc) state_d = S_EXEC;
            S_EXEC:  if (ph_tc) state_d = S_DRAIN;
            S_DRAIN: begin
                if (wr_q == NIJ_CNT) begin
                    if (kij_q == KIJ_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WMEM;
                        kij_d   = kij_q + KIJ_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                kij_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ph_last = '0;
        ph_en   = 1'b0;
        case (state_q)
            S_WMEM:  begin ph_last = WMEM_LAST; ph_en = 1'b1; end
            S_WARR:  begin ph_last = WARR_LAST; ph_en = 1'b1; end
            S_WGAP:  begin ph_last = WGAP_LAST; ph_en = 1'b1; end
            S_XMEM:  begin ph_last = XMEM_LAST; ph_en = 1'b1; end
            S_EXEC:  begin ph_last = EXEC_LAST; ph_en = 1'b1; end
            default: begin ph_last = '0;        ph_en = 1'b0; end
        endcase
        ph_load = (state_d != state_q);
    end

    // A psum write always trails the ofifo read issued in the previous word.
    always_comb begin
        rd_base = (state_q == S_DRAIN) ? rd_q : '0;
        wr_base = (state_q == S_DRAIN) ? wr_q : '0;
        rd_fire = (state_d == S_DRAIN) && bus.ofifo_valid && (rd_base < NIJ_CNT);
        wr_fire = (state_d == S_DRAIN) && inst_q[OFIFO_RD_BIT];
        rd_d    = rd_base + CNT_W'(rd_fire);
        wr_d    = wr_base + CNT_W'(wr_fire);
    end

    always_comb begin : inst_dec
        int a;
        a      = 0;
        inst_d = IDLE_WORD;
        case (state_d)
            S_WMEM: begin
                if (ph_nxt < COL_CNT) begin
                    a = W_BASE + int'(kij_d) * COL + int'(ph_nxt);
                    inst_d[XMEM_CEN_BIT] = 1'b0;
                    inst_d[XMEM_WEN_BIT] = 1'b1;
                    inst_d[XMEM_ADDR_LSB +: ADDR_W] = addr_trunc(a);
                end
                if (ph_nxt != '0) inst_d[L0_WR_BIT] = 1'b1;
            end
            S_WARR: begin
                inst_d[L0_RD_BIT] = 1'b1;
                inst_d[LOAD_BIT]  = 1'b1;
            end
            S_XMEM: begin
                if (ph_nxt < NIJ_CNT) begin
                    a = int'(ph_nxt);
                    inst_d[XMEM_CEN_BIT] = 1'b0;
                    inst_d[XMEM_WEN_BIT] = 1'b1;
                    inst_d[XMEM_ADDR_LSB +: ADDR_W] = addr_trunc(a);
                end
                if (ph_nxt != '0) inst_d[L0_WR_BIT] = 1'b1;
            end
            S_EXEC: begin
                inst_d[L0_RD_BIT]   = 1'b1;
                inst_d[EXECUTE_BIT] = 1'b1;
            end
            S_DRAIN: begin
                inst_d[OFIFO_RD_BIT] = rd_fire;
                if (wr_fire) begin
                    a = int'(kij_d) * LEN_NIJ + int'(wr_base);
                    inst_d[PSUM_CEN_BIT] = 1'b0;
                    inst_d[PSUM_WEN_BIT] = 1'b0;
                    inst_d[PSUM_ADDR_LSB +: ADDR_W] = addr_trunc(a);
                end
            end
            default: inst_d = IDLE_WORD;
        endcase
        inst_d[SFU_EN_BIT]   = 1'b0;
        inst_d[ACC_BIT]      = 1'b0;
        inst_d[IFIFO_WR_BIT] = 1'b0;
        inst_d[IFIFO_RD_BIT] = 1'b0;
        busy_d = !(state_d inside {S_IDLE, S_DONE});
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            kij_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            inst_q  <= IDLE_WORD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kij_q   <= kij_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            inst_q  <= inst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.inst = inst_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.kij  = kij_q;

endmodule

// File: tb/tb_inst_gen.sv
// Bench for inst_gen: an instruction-stream model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_inst_gen;

    localparam int ROW     = 8;
    localparam int COL     = 8;
    localparam int LEN_KIJ = 9;
    localparam int LEN_NIJ = 36;
    localparam int W_BASE  = 1024;
    localparam logic [34:0] IDLE_W = 35'h100080000;

    logic clk = 1'b0;
    logic reset;

    inst_gen_if bus_if ();

    inst_gen #(
        .ROW(ROW), .COL(COL), .LEN_KIJ(LEN_KIJ), .LEN_NIJ(LEN_NIJ), .W_BASE(W_BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Expected instruction stream: fixed per-kij schedule in a queue, drain reactive.
    typedef enum int {M_IDLE, M_SCHED, M_DRAIN, M_DONE} mmode_e;
    mmode_e      m_mode = M_IDLE;
    logic [34:0] m_q[$];
    int          m_kij = 0;
    int          m_rd = 0;
    int          m_wr = 0;
    bit          m_prev_rd = 1'b0;

    task automatic build_pass(input int k);
        logic [34:0] w;
        for (int i = 0; i <= COL; i++) begin
            w = IDLE_W;
            if (i < COL) begin w[19] = 1'b0; w[18] = 1'b1; w[17:7] = 11'(W_BASE + k * COL + i); end
            if (i >= 1) w[2] = 1'b1;
            m_q.push_back(w);
        end
        for (int i = 0; i < COL; i++) begin
            w = IDLE_W; w[3] = 1'b1; w[0] = 1'b1;
            m_q.push_back(w);
        end
        for (int i = 0; i < ROW + COL; i++) m_q.push_back(IDLE_W);
        for (int i = 0; i <= LEN_NIJ; i++) begin
            w = IDLE_W;
            if (i < LEN_NIJ) begin w[19] = 1'b0; w[18] = 1'b1; w[17:7] = 11'(i); end
            if (i >= 1) w[2] = 1'b1;
            m_q.push_back(w);
        end
        for (int i = 0; i < LEN_NIJ; i++) begin
            w = IDLE_W; w[3] = 1'b1; w[1] = 1'b1;
            m_q.push_back(w);
        end
    endtask

    logic [34:0] exp_inst;
    bit          exp_busy;
    bit          exp_done;
    int          exp_kij;
    bit          prev_xcen = 1'b1;
    logic [10:0] xmem_log[$];
    logic [10:0] psum_log[$];
    int          rd_seen = 0;
    int          done_cnt = 0;

    always begin : model_and_compare
        bit          rs;
        bit          st;
        bit          vl;
        logic [34:0] w;
        @(posedge clk);
        rs = reset;
        st = bus_if.start;
        vl = bus_if.ofifo_valid;
        if (!rs) begin
            m_mode = M_IDLE;
            m_kij  = 0;
            m_q.delete();
        end else if (m_mode == M_SCHED && m_q.size() == 0) begin
            m_mode = M_DRAIN; m_rd = 0; m_wr = 0; m_prev_rd = 1'b0;
        end else if (m_mode == M_DRAIN && m_wr == LEN_NIJ) begin
            if (m_kij == LEN_KIJ - 1) m_mode = M_DONE;
            else begin m_kij++; build_pass(m_kij); m_mode = M_SCHED; end
        end else if (m_mode == M_DONE) begin
            m_mode = M_IDLE; m_kij = 0;
        end else if (m_mode == M_IDLE && st) begin
            build_pass(m_kij); m_mode = M_SCHED;
        end
        w = IDLE_W;
        case (m_mode)
            M_SCHED: w = m_q.pop_front();
            M_DRAIN: begin
                if (m_prev_rd) begin
                    w[32] = 1'b0; w[31] = 1'b0; w[30:20] = 11'(m_kij * LEN_NIJ + m_wr);
                    m_wr++;
                end
                m_prev_rd = vl && (m_rd < LEN_NIJ);
                if (m_prev_rd) begin w[6] = 1'b1; m_rd++; end
            end
            default: w = IDLE_W;
        endcase
        exp_inst = w;
        exp_busy = (m_mode == M_SCHED) || (m_mode == M_DRAIN);
        exp_done = (m_mode == M_DONE);
        exp_kij  = m_kij;
        #1;
        check("inst", bus_if.inst, exp_inst);
        check("busy", bus_if.busy, exp_busy);
        check("done", bus_if.done, exp_done);
        check("kij", bus_if.kij, exp_kij);
        if (bus_if.inst[2]) check("l0_wr_after_xmem_read", prev_xcen, 0);
        check("load_exec_excl", bus_if.inst[0] & bus_if.inst[1], 0);
        prev_xcen = bus_if.inst[19];
        if (!bus_if.inst[19]) xmem_log.push_back(bus_if.inst[17:7]);
        if (!bus_if.inst[32]) psum_log.push_back(bus_if.inst[30:20]);
        if (bus_if.inst[6]) rd_seen++;
        if (bus_if.done) done_cnt++;
    end

    int done_base;
    int rd_base;

    initial begin
        reset = 1'b0;
        bus_if.start = 1'b0;
        bus_if.ofifo_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_inst", bus_if.inst, 35'h100080000);
        check("rst_busy", bus_if.busy, 0);
        check("rst_done", bus_if.done, 0);
        check("rst_kij", bus_if.kij, 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_inst", bus_if.inst, 35'h100080000);
        check("idle_busy", bus_if.busy, 0);

        // Full pass with ofifo_valid high, extra start during EXEC
        bus_if.ofifo_valid = 1'b1;
        xmem_log.delete(); psum_log.delete();
        done_base = done_cnt;
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        check("busy_after_start", bus_if.busy, 1);
        for (int i = 0; i < 300 && !bus_if.inst[1]; i++) @(negedge clk);
        check("reach_exec", bus_if.inst[1], 1);
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        for (int i = 0; i < 4000 && done_cnt == done_base; i++) @(negedge clk);
        check("done_seen", done_cnt - done_base, 1);
        check("done_pulse_busy", bus_if.busy, 0);
        check("done_pulse_kij", bus_if.kij, 8);
        repeat (5) @(negedge clk);
        check("single_done", done_cnt - done_base, 1);
        check("after_done_kij", bus_if.kij, 0);
        check("xmem_count", xmem_log.size(), 396);
        check("xmem_first_w", xmem_log[0], 1024);
        check("xmem_last_w0", xmem_log[7], 1031);
        check("xmem_first_act", xmem_log[8], 0);
        check("xmem_last_act", xmem_log[43], 35);
        check("xmem_kij1_w", xmem_log[44], 1032);
        check("psum_count", psum_log.size(), 324);
        check("psum_first", psum_log[0], 0);
        check("psum_kij0_last", psum_log[35], 35);
        check("psum_last", psum_log[323], 323);

        // Drain stall after 10 reads
        psum_log.delete();
        done_base = done_cnt;
        rd_base = rd_seen;
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        for (int i = 0; i < 400 && (rd_seen - rd_base) < 10; i++) @(negedge clk);
        bus_if.ofifo_valid = 1'b0;
        check("rd_at_pause", rd_seen - rd_base, 10);
        repeat (5) @(negedge clk);
        check("rd_held", rd_seen - rd_base, 10);
        check("writes_at_pause", psum_log.size(), 10);
        bus_if.ofifo_valid = 1'b1;
        for (int i = 0; i < 50 && psum_log.size() < 12; i++) @(negedge clk);
        check("psum_before_gap", psum_log[9], 9);
        check("psum_resume", psum_log[10], 10);
        check("psum_after_resume", psum_log[11], 11);

        // Reset during kij=4 drain, with a start in the same cycle
        for (int i = 0; i < 3000 && !(bus_if.kij == 4'd4 && !bus_if.inst[32]); i++) @(negedge clk);
        check("reach_kij4_drain", bus_if.kij, 4);
        reset = 1'b0;
        bus_if.start = 1'b1;
        @(negedge clk);
        check("abort_inst", bus_if.inst, 35'h100080000);
        check("abort_busy", bus_if.busy, 0);
        check("abort_kij", bus_if.kij, 0);
        reset = 1'b1;
        bus_if.start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt - done_base, 0);
        check("start_with_reset_ignored", bus_if.busy, 0);
        xmem_log.delete();
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (2) @(negedge clk);
        check("restart_xmem_count", xmem_log.size(), 3);
        check("restart_xmem_addr", xmem_log[0], 1024);
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_gen.md
INST_GEN -- requirements
Module: inst_gen

Interface
REQ-001 SHALL have parameter ROW, default 8, meaning PE array rows (activation lanes).
REQ-002 SHALL have parameter COL, default 8, meaning PE array columns (weight words per kij).
REQ-003 SHALL have parameter LEN_KIJ, default 9, meaning kernel positions per pass.
REQ-004 SHALL have parameter LEN_NIJ, default 36, meaning activation words per kij.
REQ-005 SHALL have parameter W_BASE, default 1024, meaning xmem address of the kij=0 weights; activations live at xmem 0..LEN_NIJ-1.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-008 SHALL have port start, input, 1, a one-cycle request to run one full weight-stationary pass.
REQ-009 SHALL have port ofifo_valid, input, 1, meaning the core output FIFO holds a full row.
REQ-010 SHALL have port inst, output, 35, the registered core instruction word.
REQ-011 SHALL have port busy, output, 1, high from the cycle after an accepted start until done.
REQ-012 SHALL have port done, output, 1, a one-cycle pulse at pass completion.
REQ-013 SHALL have port kij, output, 4, the current kernel index.

Function
REQ-014 SHALL use this inst field map: [34] sfu_en=0, [33] acc=0, [32] psum CEN (active-low), [31] psum WEN (active-low), [30:20] psum addr, [19] xmem CEN, [18] xmem WEN, [17:7] xmem addr, [6] ofifo_rd, [5] ififo_wr=0, [4] ififo_rd=0, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
REQ-015 SHALL drive the IDLE word 35'h100080000 (both CEN high, all else 0) in IDLE and DONE.
REQ-016 SHALL implement the states IDLE, WMEM, WARR, WGAP, XMEM, EXEC, DRAIN, DONE.
REQ-017 SHALL go IDLE->WMEM on start; start while busy SHALL be ignored.
REQ-018 WMEM SHALL last COL+1 cycles: in cycles 0..COL-1 xmem CEN=0, WEN=1, addr=W_BASE+kij*COL+i; l0_wr=1 in cycles 1..COL, covering the 1-cycle SRAM read latency.
REQ-019 WARR SHALL assert l0_rd=1 and load=1 for COL cycles.
REQ-020 WGAP SHALL drive the IDLE word for ROW+COL cycles.
REQ-021 XMEM SHALL mirror WMEM over LEN_NIJ+1 cycles with addr=i.
REQ-022 EXEC SHALL assert l0_rd=1 and execute=1 for LEN_NIJ cycles.
REQ-023 DRAIN SHALL assert ofifo_rd in exactly the cycles where ofifo_valid=1 and fewer than LEN_NIJ reads have been issued.
REQ-024 DRAIN SHALL issue a psum write one cycle after each ofifo_rd: CEN=0, WEN=0, addr=kij*LEN_NIJ+n, where n is the write count.
REQ-025 When ofifo_valid deasserts during DRAIN, the block SHALL pause with counts held and resume without skipping or duplicating an address.
REQ-026 After the LEN_NIJ-th write, the block SHALL go to WMEM with kij+1, or to DONE when kij=LEN_KIJ-1.
REQ-027 DONE SHALL last 1 cycle with done=1 and busy=0, then return to IDLE with kij=0.
REQ-028 Address arithmetic SHALL be unsigned and truncated to 11 bits; parameters SHALL be restricted so no address exceeds 2047.

Reset
REQ-029 While reset=0 at a clk edge, the block SHALL take state=IDLE, inst=35'h100080000, busy=0, done=0, kij=0, and clear all counters.
REQ-030 Reset asserted mid-pass SHALL abort the pass with no done pulse; start in the same cycle as reset SHALL be ignored.

Structure
REQ-031 The shared package core_pkg SHALL hold the inst bit-position constants, the IDLE word and the state enum.
REQ-032 The block SHALL instantiate one sub-module, step_cnt: a loadable up-counter with a terminal-count flag, reused for phase counting.

Verification
REQ-033 Reset then idle -> inst=35'h100080000, busy=0, done=0, kij=0.
REQ-034 Defaults, ofifo_valid tied to 1, start pulse -> xmem addrs 1024..1031 then 0..35 for kij=0; psum addrs 0..35; done after kij=8 with last psum addr 323.
REQ-035 ofifo_valid low for 5 cycles after 10 DRAIN reads -> ofifo_rd held at 0; psum writes resume at addr kij*36+10; no gap or duplicate.
REQ-036 start re-pulsed during EXEC -> no effect; exactly one done pulse.
REQ-037 reset=0 during kij=4 DRAIN -> next cycle inst=35'h100080000 and busy=0; a new start restarts at xmem addr 1024.
REQ-038 Every cycle -> l0_wr=1 only when the previous cycle had xmem CEN=0; load and execute never both 1.
